// File: rtl/regfile_writeback_pkg.sv
// Shared types and sizes for the register-file write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_writeback_pkg;

    localparam int DATA_W = 32;             // write data width
    localparam int ADDR_W = 5;              // register index width
    localparam int NREGS  = 1 << ADDR_W;    // architectural registers (x0 included)
    localparam int DEPTH  = 4;              // long-latency result buffer entries

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One buffered long-latency result: destination plus value.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Circular buffer of long-latency write-back entries (DEPTH x wb_entry_t).
// Latency: a push at edge N is visible at head_o after edge N; no fall-through bypass.
// Backpressure: full_o while DEPTH entries held; caller must not push when full or pop when empty.
//
// Ports: clk/reset (sync, active-high), push_i/push_dat_i write side,
//        pop_i/head_o read side, full_o/empty_o occupancy flags.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH_P = DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  wb_entry_t push_dat_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int CNT_W = $clog2(DEPTH_P + 1);

    wb_entry_t          mem_q [DEPTH_P];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    assign full_o  = (count_q == CNT_W'(DEPTH_P));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH_P is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;     // idle, or push+pop keeps occupancy
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and long-latency results onto the single regfile write port; tracks pending destinations.
// Latency: ALU result -> write 1 cycle later; long result -> earliest write 2 cycles after acceptance.
// Backpressure: ALU never stalled; lng_ready = !full (no same-cycle pop credit); stall holds decode.
//
// Ports: clk, reset (sync, active-high)
//        alu_valid/alu_rd/alu_data       ALU result, always accepted
//        lng_valid/lng_ready/lng_rd/lng_data  long-latency result handshake
//        mark_valid/mark_rd              long-latency op issued, destination becomes pending
//        rs1/rs2 -> stall                decode operand hazard check
//        signal/r_write_res/v_write_res  registered regfile write port
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH_P = DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lng_valid,
    output logic              lng_ready,
    input  logic [ADDR_W-1:0] lng_rd,
    input  logic [DATA_W-1:0] lng_data,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              stall,
    output logic              signal,
    output logic [ADDR_W-1:0] r_write_res,
    output logic [DATA_W-1:0] v_write_res
);

    wb_entry_t          push_dat;
    wb_entry_t          head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               alu_wr;

    logic               signal_q, signal_d;
    logic [ADDR_W-1:0]  r_write_q, r_write_d;
    logic [DATA_W-1:0]  v_write_q, v_write_d;
    logic [NREGS-1:0]   pending_q, pending_d;   // bit 0 is never set

    assign lng_ready = !fifo_full;
    // Results to x0 complete the handshake but are dropped.
    assign push      = lng_valid && lng_ready && (lng_rd != REG_ZERO);
    assign push_dat  = '{rd: lng_rd, data: lng_data};
    assign alu_wr    = alu_valid && (alu_rd != REG_ZERO);
    // Pop sees only entries already stored, so a push this cycle cannot write until next.
    assign pop       = !alu_wr && !fifo_empty;

    wb_fifo #(.DEPTH_P(DEPTH_P)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        signal_d  = 1'b0;
        r_write_d = r_write_q;
        v_write_d = v_write_q;
        if (alu_wr) begin
            signal_d  = 1'b1;
            r_write_d = alu_rd;
            v_write_d = alu_data;
        end else if (pop) begin
            signal_d  = 1'b1;
            r_write_d = head.rd;
            v_write_d = head.data;
        end
    end

    // Clear first, then set, so a new issue to the same register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head.rd] = 1'b0;
        end
        if (mark_valid && (mark_rd != REG_ZERO)) begin
            pending_d[mark_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            signal_q  <= 1'b0;
            r_write_q <= '0;
            v_write_q <= '0;
            pending_q <= '0;
        end else begin
            signal_q  <= signal_d;
            r_write_q <= r_write_d;
            v_write_q <= v_write_d;
            pending_q <= pending_d;
        end
    end

    // pending_q[0] is held at zero, so x0 operands never stall.
    assign stall       = pending_q[rs1] || pending_q[rs2];
    assign signal      = signal_q;
    assign r_write_res = r_write_q;
    assign v_write_res = v_write_q;

endmodule
